mm_refill_arbiter: RTL and testbench

Miss-handling controller and arbiter for the single main-memory read port shared by the instruction cache and the data cache. Both caches are direct-mapped with 2-word (64-bit) blocks.
- Accepts level miss requests from both caches and grants one at a time, round-robin on ties.
- Fetches the 64-bit block as two 32-bit memory beats.
- Pulses the fill strobe (the cache's Access_MM input) with the assembled block.
- Drives per-side stall signals and per-side refill counters.

---
 rtl/mm_refill_arbiter.sv | 146 ++++++++++++++
 tb/tb_mm_refill_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_refill_arbiter.sv
// Refill controller for the single main-memory read port shared by the I- and D-cache.
// It arbitrates the two miss requests, fetches each 2-word block as two beats and strobes the fill.
module mm_refill_arbiter #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 20
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              I_MISS,
  input  logic [ADDR_W-1:0] I_ADDR,
  input  logic              D_MISS,
  input  logic [ADDR_W-1:0] D_ADDR,
  output logic              MM_REQ,
  output logic [ADDR_W-1:0] MM_ADDR,
  input  logic              MM_ACK,
  input  logic              MM_RVALID,
  input  logic [31:0]       MM_RDATA,
  output logic              I_FILL,
  output logic              D_FILL,
  output logic [63:0]       FILL_DATA,
  output logic              I_STALL,
  output logic              D_STALL,
  output logic              BUSY,
  output logic [CNT_W-1:0]  CNT_I_REFILL,
  output logic [CNT_W-1:0]  CNT_D_REFILL
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_BEAT0,
    S_BEAT1,
    S_FILL
  } state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_t;

  localparam logic [ADDR_W-1:0] BLOCK_MASK = ~{{(ADDR_W-3){1'b0}}, 3'b111};

  state_t              r_state;
  side_t               r_owner;
  side_t               r_last_grant;
  logic                r_mm_req;
  logic [ADDR_W-1:0]   r_mm_addr;
  logic                r_i_fill;
  logic                r_d_fill;
  logic [63:0]         r_fill_data;
  logic [CNT_W-1:0]    r_cnt_i;
  logic [CNT_W-1:0]    r_cnt_d;

  logic                w_any_miss;
  logic                w_grant_d;
  logic [ADDR_W-1:0]   w_grant_addr;

  // On a tie the side that was not served last wins.
  assign w_any_miss   = I_MISS | D_MISS;
  assign w_grant_d    = D_MISS & (~I_MISS | (r_last_grant == SIDE_I));
  assign w_grant_addr = w_grant_d ? D_ADDR : I_ADDR;

  // NOTE: every state register below uses non-blocking assignment so all of them
  // update together on the clock edge, independent of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state      <= S_IDLE;
      r_owner      <= SIDE_I;
      r_last_grant <= SIDE_I;
      r_mm_req     <= 1'b0;
      r_mm_addr    <= '0;
      r_i_fill     <= 1'b0;
      r_d_fill     <= 1'b0;
      r_fill_data  <= '0;
      r_cnt_i      <= '0;
      r_cnt_d      <= '0;
    end else begin
      // NOTE: the fill strobes default low every cycle so they are single-cycle pulses
      // raised only on the transition into FILL.
      r_i_fill <= 1'b0;
      r_d_fill <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_any_miss) begin
            r_owner   <= w_grant_d ? SIDE_D : SIDE_I;
            r_mm_addr <= w_grant_addr & BLOCK_MASK;
            r_mm_req  <= 1'b1;
            r_state   <= S_REQ;
          end
        end

        S_REQ: begin
          if (MM_ACK) begin
            r_mm_req <= 1'b0;
            r_state  <= S_BEAT0;
          end
        end

        S_BEAT0: begin
          if (MM_RVALID) begin
            r_fill_data[31:0] <= MM_RDATA;
            r_state           <= S_BEAT1;
          end
        end

        S_BEAT1: begin
          if (MM_RVALID) begin
            r_fill_data[63:32] <= MM_RDATA;
            r_i_fill           <= (r_owner == SIDE_I);
            r_d_fill           <= (r_owner == SIDE_D);
            r_state            <= S_FILL;
          end
        end

        S_FILL: begin
          if (r_owner == SIDE_I) begin
            r_cnt_i <= r_cnt_i + CNT_W'(1);
          end else begin
            r_cnt_d <= r_cnt_d + CNT_W'(1);
          end
          r_last_grant <= r_owner;
          r_state      <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign MM_REQ       = r_mm_req;
  assign MM_ADDR      = r_mm_addr;
  assign I_FILL       = r_i_fill;
  assign D_FILL       = r_d_fill;
  assign FILL_DATA    = r_fill_data;
  assign CNT_I_REFILL = r_cnt_i;
  assign CNT_D_REFILL = r_cnt_d;
  assign BUSY         = (r_state != S_IDLE);

  // The side waiting behind the owner stalls only through its own miss level.
  assign I_STALL = I_MISS | (BUSY & (r_owner == SIDE_I));
  assign D_STALL = D_MISS | (BUSY & (r_owner == SIDE_D));

endmodule

// File: tb/tb_mm_refill_arbiter.sv
// Randomised bench for mm_refill_arbiter: a transaction-level memory responder plus
// a small arbitration/counter model; a second instance with 2-bit counters covers wrap.
module tb_mm_refill_arbiter;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 20;
  localparam int CNT_W2 = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              i_miss, d_miss;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic              mm_ack, mm_rvalid;
  logic [31:0]       mm_rdata;

  logic              mm_req, i_fill, d_fill, i_stall, d_stall, busy;
  logic [ADDR_W-1:0] mm_addr;
  logic [63:0]       fill_data;
  logic [CNT_W-1:0]  cnt_i, cnt_d;

  logic              w2_mm_req, w2_i_fill, w2_d_fill, w2_i_stall, w2_d_stall, w2_busy;
  logic [ADDR_W-1:0] w2_mm_addr;
  logic [63:0]       w2_fill_data;
  logic [CNT_W2-1:0] w2_cnt_i, w2_cnt_d;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: who was served last and how many refills each side completed.
  bit          m_last_d;
  int unsigned m_cnt_i, m_cnt_d;

  always #5 clk = ~clk;

  mm_refill_arbiter #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .CLK(clk), .RESET(reset),
    .I_MISS(i_miss), .I_ADDR(i_addr), .D_MISS(d_miss), .D_ADDR(d_addr),
    .MM_REQ(mm_req), .MM_ADDR(mm_addr), .MM_ACK(mm_ack),
    .MM_RVALID(mm_rvalid), .MM_RDATA(mm_rdata),
    .I_FILL(i_fill), .D_FILL(d_fill), .FILL_DATA(fill_data),
    .I_STALL(i_stall), .D_STALL(d_stall), .BUSY(busy),
    .CNT_I_REFILL(cnt_i), .CNT_D_REFILL(cnt_d)
  );

  mm_refill_arbiter #(.ADDR_W(ADDR_W), .CNT_W(CNT_W2)) dut_w2 (
    .CLK(clk), .RESET(reset),
    .I_MISS(i_miss), .I_ADDR(i_addr), .D_MISS(d_miss), .D_ADDR(d_addr),
    .MM_REQ(w2_mm_req), .MM_ADDR(w2_mm_addr), .MM_ACK(mm_ack),
    .MM_RVALID(mm_rvalid), .MM_RDATA(mm_rdata),
    .I_FILL(w2_i_fill), .D_FILL(w2_d_fill), .FILL_DATA(w2_fill_data),
    .I_STALL(w2_i_stall), .D_STALL(w2_d_stall), .BUSY(w2_busy),
    .CNT_I_REFILL(w2_cnt_i), .CNT_D_REFILL(w2_cnt_d)
  );

  task automatic do_reset();
    @(negedge clk);
    i_miss = 1'b0; d_miss = 1'b0; mm_ack = 1'b0; mm_rvalid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_last_d = 1'b0; m_cnt_i = 0; m_cnt_d = 0;
  endtask

  // Serves one refill as the memory; called at a negedge with the miss inputs already set.
  task automatic run_refill(input int ack_dly, input int gap, input bit early_rv,
                            input bit raise_other, input logic [31:0] w0, input logic [31:0] w1);
    bit                want_d;
    logic [ADDR_W-1:0] exp_addr;
    logic [CNT_W-1:0]  e_ci, e_cd;
    logic [CNT_W2-1:0] e2_ci, e2_cd;
    want_d   = (i_miss && d_miss) ? !m_last_d : d_miss;
    exp_addr = (want_d ? d_addr : i_addr) & 32'hFFFF_FFF8;

    @(negedge clk);
    vectors++;
    if ({mm_req, busy, i_fill, d_fill} !== 4'b1100 || mm_addr !== exp_addr) begin
      miscompares++;
      $display("FAIL grant: req/busy/ifill/dfill=%b addr=%h, required 1100 addr=%h (side %s)",
               {mm_req, busy, i_fill, d_fill}, mm_addr, exp_addr, want_d ? "D" : "I");
    end
    vectors++;
    if ((want_d ? d_stall : i_stall) !== 1'b1) begin
      miscompares++;
      $display("FAIL owner_stall: got %b, required 1", want_d ? d_stall : i_stall);
    end

    for (int k = 0; k < ack_dly; k++) begin
      mm_ack = 1'b0; mm_rvalid = early_rv ? 1'($urandom_range(0, 1)) : 1'b0; mm_rdata = $urandom;
      @(negedge clk);
      vectors++;
      if (mm_req !== 1'b1 || busy !== 1'b1 || mm_addr !== exp_addr) begin
        miscompares++;
        $display("FAIL req_hold: req=%b busy=%b addr=%h, required 1 1 %h", mm_req, busy, mm_addr, exp_addr);
      end
    end
    mm_ack = 1'b1; mm_rvalid = early_rv; mm_rdata = $urandom;
    @(negedge clk);
    mm_ack = 1'b0; mm_rvalid = 1'b0;
    vectors++;
    if ({mm_req, busy, i_fill, d_fill} !== 4'b0100) begin
      miscompares++;
      $display("FAIL ack_release: req/busy/ifill/dfill=%b, required 0100", {mm_req, busy, i_fill, d_fill});
    end

    if (raise_other && !(want_d ? i_miss : d_miss)) begin
      if (want_d) begin i_addr = $urandom; i_miss = 1'b1; end
      else begin d_addr = $urandom; d_miss = 1'b1; end
      #1;
      vectors++;
      if ({i_stall, d_stall} !== 2'b11) begin
        miscompares++;
        $display("FAIL queued_stall: i/d stall=%b, required 11", {i_stall, d_stall});
      end
    end

    repeat (gap) begin
      mm_rdata = $urandom;
      @(negedge clk);
      vectors++;
      if ({mm_req, busy, i_fill, d_fill} !== 4'b0100) begin
        miscompares++;
        $display("FAIL beat0_wait: req/busy/ifill/dfill=%b, required 0100", {mm_req, busy, i_fill, d_fill});
      end
    end
    mm_rvalid = 1'b1; mm_rdata = w0;
    @(negedge clk);
    mm_rvalid = 1'b0; mm_rdata = $urandom;
    vectors++;
    if ({mm_req, busy, i_fill, d_fill} !== 4'b0100) begin
      miscompares++;
      $display("FAIL beat1_enter: req/busy/ifill/dfill=%b, required 0100", {mm_req, busy, i_fill, d_fill});
    end
    repeat (gap) begin
      mm_rdata = $urandom;
      @(negedge clk);
      vectors++;
      if ({mm_req, busy, i_fill, d_fill} !== 4'b0100) begin
        miscompares++;
        $display("FAIL beat1_wait: req/busy/ifill/dfill=%b, required 0100", {mm_req, busy, i_fill, d_fill});
      end
    end
    mm_rvalid = 1'b1; mm_rdata = w1;
    @(negedge clk);
    mm_rvalid = 1'b0; mm_rdata = $urandom;
    vectors++;
    if ({mm_req, busy, i_fill, d_fill} !== {2'b01, !want_d, want_d} || fill_data !== {w1, w0}) begin
      miscompares++;
      $display("FAIL fill: req/busy/ifill/dfill=%b data=%h, required %b data=%h",
               {mm_req, busy, i_fill, d_fill}, fill_data, {2'b01, !want_d, want_d}, {w1, w0});
    end
    vectors++;
    if ((want_d ? d_stall : i_stall) !== 1'b1) begin
      miscompares++;
      $display("FAIL fill_stall: got %b, required 1", want_d ? d_stall : i_stall);
    end

    m_last_d = want_d;
    if (want_d) m_cnt_d++; else m_cnt_i++;
    if (want_d) d_miss = 1'b0; else i_miss = 1'b0;

    @(negedge clk);
    vectors++;
    if ({mm_req, busy, i_fill, d_fill} !== 4'b0000 || {i_stall, d_stall} !== {i_miss, d_miss}) begin
      miscompares++;
      $display("FAIL idle_after_fill: req/busy/ifill/dfill=%b stalls=%b, required 0000 stalls=%b",
               {mm_req, busy, i_fill, d_fill}, {i_stall, d_stall}, {i_miss, d_miss});
    end
    e_ci = m_cnt_i[CNT_W-1:0];   e_cd = m_cnt_d[CNT_W-1:0];
    e2_ci = m_cnt_i[CNT_W2-1:0]; e2_cd = m_cnt_d[CNT_W2-1:0];
    vectors++;
    if (cnt_i !== e_ci || cnt_d !== e_cd) begin
      miscompares++;
      $display("FAIL counters: i=%0d d=%0d, required i=%0d d=%0d", cnt_i, cnt_d, e_ci, e_cd);
    end
    vectors++;
    if (w2_cnt_i !== e2_ci || w2_cnt_d !== e2_cd) begin
      miscompares++;
      $display("FAIL counters_w2: i=%0d d=%0d, required i=%0d d=%0d", w2_cnt_i, w2_cnt_d, e2_ci, e2_cd);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; i_miss = 1'b0; d_miss = 1'b0; i_addr = '0; d_addr = '0;
    mm_ack = 1'b0; mm_rvalid = 1'b0; mm_rdata = '0;
    #1 reset = 1'b1;
    #2;
    vectors++;
    if ({mm_req, busy, i_fill, d_fill, i_stall, d_stall} !== 6'b0 || mm_addr !== '0 ||
        fill_data !== '0 || cnt_i !== '0 || cnt_d !== '0) begin
      miscompares++;
      $display("FAIL reset_state: flags=%b addr=%h data=%h cnt=%0d/%0d, required all zero",
               {mm_req, busy, i_fill, d_fill, i_stall, d_stall}, mm_addr, fill_data, cnt_i, cnt_d);
    end
    @(negedge clk);
    reset = 1'b0;
    m_last_d = 1'b0; m_cnt_i = 0; m_cnt_d = 0;
    @(negedge clk);
    vectors++;
    if ({mm_req, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_no_miss: req/busy=%b, required 00", {mm_req, busy});
    end
  endtask

  task automatic test_single_i();
    do_reset();
    i_addr = 32'h0000_004C; i_miss = 1'b1;
    run_refill(0, 0, 1'b0, 1'b0, 32'hAAAA_0001, 32'hBBBB_0002);
    vectors++;
    if (cnt_i !== 20'd1 || cnt_d !== 20'd0) begin
      miscompares++;
      $display("FAIL single_i_count: i=%0d d=%0d, required 1/0", cnt_i, cnt_d);
    end
  endtask

  task automatic test_tie_alternate();
    do_reset();
    for (int r = 0; r < 2; r++) begin
      i_addr = $urandom; d_addr = $urandom; i_miss = 1'b1; d_miss = 1'b1;
      #1;
      vectors++;
      if ({i_stall, d_stall} !== 2'b11) begin
        miscompares++;
        $display("FAIL tie_stall: i/d stall=%b, required 11", {i_stall, d_stall});
      end
      run_refill(0, 0, 1'b0, 1'b0, $urandom, $urandom);
      run_refill(0, 0, 1'b0, 1'b0, $urandom, $urandom);
    end
    vectors++;
    if (cnt_i !== 20'd2 || cnt_d !== 20'd2) begin
      miscompares++;
      $display("FAIL tie_counts: i=%0d d=%0d, required 2/2", cnt_i, cnt_d);
    end
  endtask

  task automatic test_delayed_ack();
    d_addr = $urandom; d_miss = 1'b1;
    run_refill(3, 0, 1'b1, 1'b0, $urandom, $urandom);
  endtask

  task automatic test_gapped_beats();
    i_addr = $urandom; i_miss = 1'b1;
    run_refill(1, 2, 1'b0, 1'b1, $urandom, $urandom);
    run_refill(0, 0, 1'b0, 1'b0, $urandom, $urandom);
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      if (!i_miss && !d_miss) begin
        case ($urandom_range(0, 2))
          0: begin i_addr = $urandom; i_miss = 1'b1; end
          1: begin d_addr = $urandom; d_miss = 1'b1; end
          default: begin i_addr = $urandom; d_addr = $urandom; i_miss = 1'b1; d_miss = 1'b1; end
        endcase
      end
      run_refill($urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom, $urandom);
    end
    while (i_miss || d_miss) run_refill(0, 0, 1'b0, 1'b0, $urandom, $urandom);
  endtask

  task automatic test_reset_mid_beat1();
    do_reset();
    i_addr = $urandom; i_miss = 1'b1;
    run_refill(0, 0, 1'b0, 1'b0, $urandom, $urandom);
    i_addr = $urandom; i_miss = 1'b1;
    @(negedge clk);
    mm_ack = 1'b1;
    @(negedge clk);
    mm_ack = 1'b0; mm_rvalid = 1'b1; mm_rdata = 32'h1234_5678;
    @(negedge clk);
    mm_rvalid = 1'b0;
    vectors++;
    if (fill_data[31:0] !== 32'h1234_5678 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_beat0: low=%h busy=%b, required 12345678 1", fill_data[31:0], busy);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({mm_req, busy, i_fill, d_fill} !== 4'b0 || mm_addr !== '0 || fill_data !== '0 ||
        cnt_i !== '0 || cnt_d !== '0 || w2_cnt_i !== '0) begin
      miscompares++;
      $display("FAIL async_reset: flags=%b addr=%h data=%h cnt=%0d/%0d, required all zero",
               {mm_req, busy, i_fill, d_fill}, mm_addr, fill_data, cnt_i, cnt_d);
    end
    i_miss = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_last_d = 1'b0; m_cnt_i = 0; m_cnt_d = 0;
    for (int k = 0; k < 4; k++) begin
      mm_rvalid = 1'b1; mm_rdata = $urandom;
      @(negedge clk);
      vectors++;
      if ({busy, i_fill, d_fill} !== 3'b000) begin
        miscompares++;
        $display("FAIL stale_beat: busy/ifill/dfill=%b, required 000", {busy, i_fill, d_fill});
      end
    end
    mm_rvalid = 1'b0;
  endtask

  task automatic test_counter_wrap();
    logic [CNT_W2-1:0] seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int n = 0; n < 5; n++) begin
      i_addr = $urandom; i_miss = 1'b1;
      run_refill(0, 0, 1'b0, 1'b0, $urandom, $urandom);
      vectors++;
      if (w2_cnt_i !== seq[n] || w2_cnt_d !== 2'd0) begin
        miscompares++;
        $display("FAIL wrap_seq[%0d]: i=%0d d=%0d, required %0d/0", n, w2_cnt_i, w2_cnt_d, seq[n]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_i();
    test_tie_alternate();
    test_delayed_ack();
    test_gapped_beats();
    test_random();
    test_reset_mid_beat1();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
